// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: word width, Ldl opcode decode, fetch FSM states
// and the fetched-word queue entry.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] OP_LDL_MASK  = 16'hFFF0;
  localparam logic [WORD_W-1:0] OP_LDL_MATCH = 16'hFF10;

  typedef enum logic {
    S_OP,
    S_LIT
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] addr;
  } fetch_entry_t;

  // True when the word is an Ldl opcode that carries a trailing literal word.
  function automatic logic is_ldl(input logic [WORD_W-1:0] w);
    return (w & OP_LDL_MASK) == OP_LDL_MATCH;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {word, addr} entries with a flush that wins over
// push and pop. Head entry and empty flag are combinational views of state.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_c,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_c
);

  fetch_entry_t     buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_c  = buf_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_c = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues addresses to memory, queues returned words,
// glues Ldl opcodes to their literal and hands instructions to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_bus,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] literal,
  output logic              has_literal,
  output logic [WORD_W-1:0] instr_pc
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [WORD_W-1:0] tag_q, tag_d;
  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] hold_word_q, hold_word_d;
  logic [WORD_W-1:0] hold_pc_q, hold_pc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] lit_q, lit_d;
  logic              has_lit_q, has_lit_d;
  logic [WORD_W-1:0] ipc_q, ipc_d;

  logic              issue;
  logic              slot_free;
  logic              q_pop;
  fetch_entry_t      q_push_entry;
  fetch_entry_t      q_head;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty;

  assign q_push_entry = '{word: i_bus, addr: tag_q};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (inflight_q),
    .push_entry_i (q_push_entry),
    .pop_i        (q_pop),
    .flush_i      (redirect),
    .head_c       (q_head),
    .count_o      (q_count),
    .empty_c      (q_empty)
  );

  // Issue: the in-flight word is counted against capacity so the queue never overflows.
  always_comb begin
    issue      = (SUM_W'(q_count) + SUM_W'(inflight_q)) < SUM_W'(QDEPTH);
    pc_d       = pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    if (redirect) begin
      pc_d = redirect_addr;
    end else if (issue) begin
      pc_d       = pc_q + WORD_W'(1);
      inflight_d = 1'b1;
      tag_d      = pc_q;
    end
  end

  // Assembler FSM and output slot.
  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    valid_d     = valid_q && !instr_ready;
    instr_d     = instr_q;
    lit_d       = lit_q;
    has_lit_d   = has_lit_q;
    ipc_d       = ipc_q;
    q_pop       = 1'b0;
    slot_free   = !valid_q || instr_ready;
    if (redirect) begin
      state_d = S_OP;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          if (!q_empty && slot_free) begin
            q_pop = 1'b1;
            if (is_ldl(q_head.word)) begin
              hold_word_d = q_head.word;
              hold_pc_d   = q_head.addr;
              state_d     = S_LIT;
            end else begin
              valid_d   = 1'b1;
              instr_d   = q_head.word;
              lit_d     = '0;
              has_lit_d = 1'b0;
              ipc_d     = q_head.addr;
            end
          end
        end
        S_LIT: begin
          if (!q_empty && slot_free) begin
            q_pop     = 1'b1;
            valid_d   = 1'b1;
            instr_d   = hold_word_q;
            lit_d     = q_head.word;
            has_lit_d = 1'b1;
            ipc_d     = hold_pc_q;
            state_d   = S_OP;
          end
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      state_q     <= S_OP;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      lit_q       <= '0;
      has_lit_q   <= 1'b0;
      ipc_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      lit_q       <= lit_d;
      has_lit_q   <= has_lit_d;
      ipc_q       <= ipc_d;
    end
  end

  assign i_addr      = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign literal     = lit_q;
  assign has_literal = has_lit_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs push expected transfers,
// monitors pop and compare on every valid/ready handshake.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] lit;
    logic        has;
    logic [15:0] pc;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] mem [0:65535];

  logic [15:0] i_addr, i_bus, redirect_addr, instr, literal, instr_pc;
  logic        redirect, instr_valid, instr_ready, has_literal;

  logic [15:0] w_addr, w_bus, w_instr, w_literal, w_pc;
  logic        w_valid, w_ready, w_has;

  int checks = 0;
  int passed = 0;
  xfer_t exp_q[$];
  xfer_t wexp_q[$];

  always @(posedge clk) begin
    i_bus <= mem[i_addr];
    w_bus <= mem[w_addr];
  end

  fetch_unit #(.QDEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_bus(i_bus),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .literal(literal), .has_literal(has_literal), .instr_pc(instr_pc)
  );

  fetch_unit #(.QDEPTH(4), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .i_addr(w_addr), .i_bus(w_bus),
    .redirect(1'b0), .redirect_addr(16'h0000),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .literal(w_literal), .has_literal(w_has), .instr_pc(w_pc)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [15:0] l, input logic h,
                          input logic [15:0] p);
    exp_q.push_back('{instr: i, lit: l, has: h, pc: p});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges; the next rising edge after this returns is E0.
  task automatic start_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    instr_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d transfers outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    xfer_t e, g;
    if (!rst && instr_valid && instr_ready) begin
      g = '{instr: instr, lit: literal, has: has_literal, pc: instr_pc};
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_xfer: got instr=%h pc=%h, required no transfer", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("xfer", 64'(g), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    xfer_t e, g;
    if (!rst && w_valid && w_ready) begin
      g = '{instr: w_instr, lit: w_literal, has: w_has, pc: w_pc};
      if (wexp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_wrap_xfer: got instr=%h pc=%h, required no transfer", w_instr, w_pc);
      end else begin
        e = wexp_q.pop_front();
        check("wrap_xfer", 64'(g), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; redirect = 1'b0; redirect_addr = 16'h0000;
    instr_ready = 1'b0; w_ready = 1'b0;
    for (int k = 0; k < 65536; k++) mem[k] = 16'(k) ^ 16'h5A00;

    // Plain opcodes: reset values, E2 latency, back-to-back output.
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    push_exp(16'h1234, 16'h0000, 1'b0, 16'h0000);
    push_exp(16'h5678, 16'h0000, 1'b0, 16'h0001);
    instr_ready = 1'b1;
    tick();
    check("rst_i_addr", 64'(i_addr), 64'h0000);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'h0000);
    check("rst_literal", 64'(literal), 64'h0000);
    check("rst_has_literal", 64'(has_literal), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'h0000);
    check("rst_wrap_i_addr", 64'(w_addr), 64'hFFFE);
    tick();
    rst = 1'b0;
    tick();
    check("t1_i_addr_e0", 64'(i_addr), 64'h0001);
    tick();
    check("t1_valid_e1", 64'(instr_valid), 64'd0);
    tick();
    check("t1_valid_e2", 64'(instr_valid), 64'd1);
    tick();
    check("t1_pc_e3", 64'(instr_pc), 64'h0001);
    drain(20, cyc);

    // Ldl opcode with literal followed by a plain opcode.
    mem[0] = 16'hFF10; mem[1] = 16'h0048; mem[2] = 16'hE801;
    push_exp(16'hFF10, 16'h0048, 1'b1, 16'h0000);
    push_exp(16'hE801, 16'h0000, 1'b0, 16'h0002);
    instr_ready = 1'b1;
    start_reset();
    tick(); tick(); tick();
    check("t2_valid_e2", 64'(instr_valid), 64'd0);
    tick();
    check("t2_valid_e3", 64'(instr_valid), 64'd1);
    drain(20, cyc);

    // Back-pressure: issue stalls at 1+QDEPTH, then words drain without gaps.
    for (int k = 0; k < 6; k++) mem[k] = 16'h0100 + 16'(k);
    instr_ready = 1'b0;
    start_reset();
    tick(); tick(); tick();
    check("t3_first_valid", 64'(instr_valid), 64'd1);
    repeat (10) tick();
    check("t3_i_addr_stall", 64'(i_addr), 64'h0005);
    check("t3_instr_held", 64'(instr), 64'h0100);
    for (int k = 0; k < 6; k++) push_exp(16'h0100 + 16'(k), 16'h0000, 1'b0, 16'(k));
    drain(20, cyc);
    check("t3_no_gaps", 64'(cyc), 64'd6);

    // Redirect while an Ldl opcode waits in S_LIT.
    mem[0] = 16'hFF10; mem[1] = 16'h0048; mem[16'h20] = 16'h2222; mem[16'h21] = 16'h3333;
    push_exp(16'h2222, 16'h0000, 1'b0, 16'h0020);
    instr_ready = 1'b1;
    start_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_addr = 16'h0020;
    tick();
    redirect = 1'b0;
    check("t4_valid_r", 64'(instr_valid), 64'd0);
    check("t4_i_addr_r", 64'(i_addr), 64'h0020);
    tick();
    check("t4_valid_r1", 64'(instr_valid), 64'd0);
    tick();
    check("t4_valid_r2", 64'(instr_valid), 64'd0);
    tick();
    check("t4_valid_r3", 64'(instr_valid), 64'd1);
    drain(10, cyc);

    // Address wrap from RESET_PC = FFFE.
    mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222; mem[0] = 16'h3333; mem[1] = 16'h4444;
    wexp_q.push_back('{instr: 16'h1111, lit: 16'h0000, has: 1'b0, pc: 16'hFFFE});
    wexp_q.push_back('{instr: 16'h2222, lit: 16'h0000, has: 1'b0, pc: 16'hFFFF});
    wexp_q.push_back('{instr: 16'h3333, lit: 16'h0000, has: 1'b0, pc: 16'h0000});
    w_ready = 1'b1;
    start_reset();
    tick();
    check("t5_wrap_i_addr_e0", 64'(w_addr), 64'hFFFF);
    cyc = 0;
    while (wexp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    w_ready = 1'b0;
    if (wexp_q.size() != 0) begin
      checks++;
      $display("FAIL wrap_timeout: %0d transfers outstanding, required 0", wexp_q.size());
      wexp_q.delete();
    end

    // Asynchronous reset with a full queue and a valid output.
    mem[0] = 16'h0AA0; mem[1] = 16'h0BB1;
    instr_ready = 1'b0;
    start_reset();
    repeat (8) tick();
    check("t6_pre_valid", 64'(instr_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(instr_valid), 64'd0);
    check("t6_async_instr", 64'(instr), 64'h0000);
    check("t6_async_pc", 64'(instr_pc), 64'h0000);
    check("t6_async_i_addr", 64'(i_addr), 64'h0000);
    tick();
    rst = 1'b0;
    push_exp(16'h0AA0, 16'h0000, 1'b0, 16'h0000);
    push_exp(16'h0BB1, 16'h0000, 1'b0, 16'h0001);
    instr_ready = 1'b1;
    tick(); tick();
    check("t6_valid_e1", 64'(instr_valid), 64'd0);
    tick();
    check("t6_valid_e2", 64'(instr_valid), 64'd1);
    drain(20, cyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
